// File: rtl/peak_finder_if.sv
// Sample/report bundle for peak_finder: FFT bin stream in, one peak report per frame out.
interface peak_finder_if #(
    parameter int BW = 9
);
    logic          in_valid;
    logic [31:0]   data_in;
    logic          peak_valid;
    logic [BW-1:0] peak_bin;
    logic [16:0]   peak_mag;
    logic [16:0]   mag_left;
    logic [16:0]   mag_right;
    logic          no_signal;
    logic          busy;

    modport master (
        output in_valid, data_in,
        input  peak_valid, peak_bin, peak_mag, mag_left, mag_right, no_signal, busy
    );

    modport slave (
        input  in_valid, data_in,
        output peak_valid, peak_bin, peak_mag, mag_left, mag_right, no_signal, busy
    );
endinterface

// File: rtl/peak_finder.sv
// Scans one FFT frame for the largest-magnitude bin in [MIN_BIN, MAX_BIN] and reports it
// together with its two neighbour magnitudes; two-stage datapath (abs, then magnitude/compare).
module peak_finder #(
    parameter int N       = 512,
    parameter int MIN_BIN = 2,
    parameter int MAX_BIN = 255,
    parameter int THRESH  = 64
) (
    input  logic            clk,
    input  logic            reset,
    peak_finder_if.slave    pf
);
    localparam int BW = $clog2(N);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SCAN     = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;
    localparam logic [1:0] WAIT_LOW = 2'd3;

    localparam logic [BW-1:0] LAST_B = BW'(N - 1);
    localparam logic [BW-1:0] MIN_B  = BW'(MIN_BIN);
    localparam logic [BW-1:0] MAX_B  = BW'(MAX_BIN);
    localparam logic [16:0]   THR    = 17'(THRESH);

    logic [1:0]    state;
    logic [BW-1:0] bin_cnt;

    // stage 1
    logic          s1_vld;
    logic [15:0]   s1_re, s1_im;
    logic [BW-1:0] s1_bin;

    // stage 2 running best
    logic [16:0]   prev_mag;
    logic [16:0]   best_mag, best_left, best_right;
    logic [BW-1:0] best_bin;
    logic          right_pend;

    logic          sample;
    logic          report;
    logic [15:0]   mx, mn;
    logic [16:0]   mag;
    logic          in_range, take;

    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

    assign sample  = pf.in_valid && (state == IDLE || state == SCAN);
    // last bin leaves stage 1 on the first FLUSH edge, so the second one reports
    assign report  = (state == FLUSH) && !s1_vld;
    assign pf.busy = (state == SCAN) || (state == FLUSH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bin_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pf.in_valid) begin
                        state   <= SCAN;
                        bin_cnt <= BW'(1);
                    end
                end
                SCAN: begin
                    if (!pf.in_valid) begin
                        state   <= IDLE;
                        bin_cnt <= '0;
                    end else if (bin_cnt == LAST_B) begin
                        state   <= FLUSH;
                        bin_cnt <= '0;
                    end else begin
                        bin_cnt <= bin_cnt + BW'(1);
                    end
                end
                FLUSH: begin
                    if (report)
                        state <= pf.in_valid ? WAIT_LOW : IDLE;
                end
                default: begin
                    if (!pf.in_valid)
                        state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld <= 1'b0;
            s1_re  <= '0;
            s1_im  <= '0;
            s1_bin <= '0;
        end else begin
            s1_vld <= sample;
            if (sample) begin
                s1_re  <= abs16(pf.data_in[31:16]);
                s1_im  <= abs16(pf.data_in[15:0]);
                s1_bin <= bin_cnt;
            end
        end
    end

    always_comb begin
        mx       = (s1_re >= s1_im) ? s1_re : s1_im;
        mn       = (s1_re >= s1_im) ? s1_im : s1_re;
        mag      = {1'b0, mx} + {2'b00, mn[15:1]};
        in_range = (s1_bin >= MIN_B) && (s1_bin <= MAX_B);
        // MIN_BIN seeds the search; later bins must be strictly larger so ties keep the lowest
        take     = s1_vld && in_range && ((s1_bin == MIN_B) || (mag > best_mag));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_mag   <= '0;
            best_mag   <= '0;
            best_bin   <= '0;
            best_left  <= '0;
            best_right <= '0;
            right_pend <= 1'b0;
        end else if (s1_vld) begin
            prev_mag <= mag;
            if (take) begin
                best_mag   <= mag;
                best_bin   <= s1_bin;
                best_left  <= prev_mag;
                right_pend <= 1'b1;
            end else if (right_pend) begin
                best_right <= mag;
                right_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pf.peak_valid <= 1'b0;
            pf.peak_bin   <= '0;
            pf.peak_mag   <= '0;
            pf.mag_left   <= '0;
            pf.mag_right  <= '0;
            pf.no_signal  <= 1'b0;
        end else begin
            pf.peak_valid <= report;
            if (report) begin
                pf.peak_bin  <= best_bin;
                pf.peak_mag  <= best_mag;
                pf.mag_left  <= best_left;
                pf.mag_right <= best_right;
                pf.no_signal <= (best_mag < THR);
            end
        end
    end
endmodule

// File: tb/tb_peak_finder.sv
// Directed and randomized frames for peak_finder, checked against an array-based reference model.
module tb_peak_finder;
    localparam int N       = 512;
    localparam int MIN_BIN = 2;
    localparam int MAX_BIN = 255;
    localparam int THRESH  = 64;

    logic clk = 1'b0;
    logic reset;

    peak_finder_if bus ();

    peak_finder #(.N(N), .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN), .THRESH(THRESH)) dut (
        .clk   (clk),
        .reset (reset),
        .pf    (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] frame [N];
    int exp_bin, exp_mag, exp_left, exp_right, exp_ns;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int mag_of(input logic [31:0] w);
        int re, im, ar, ai;
        re = int'($signed(w[31:16]));
        im = int'($signed(w[15:0]));
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        return ((ar > ai) ? ar : ai) + ((ar > ai) ? ai : ar) / 2;
    endfunction

    task automatic model();
        int m [N];
        int best;
        for (int i = 0; i < N; i++) m[i] = mag_of(frame[i]);
        best = MIN_BIN;
        for (int b = MIN_BIN + 1; b <= MAX_BIN; b++)
            if (m[b] > m[best]) best = b;
        exp_bin   = best;
        exp_mag   = m[best];
        exp_left  = m[best - 1];
        exp_right = m[best + 1];
        exp_ns    = (m[best] < THRESH) ? 1 : 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".bin"},   32'(bus.peak_bin),  32'(exp_bin));
        chk({tag, ".mag"},   32'(bus.peak_mag),  32'(exp_mag));
        chk({tag, ".left"},  32'(bus.mag_left),  32'(exp_left));
        chk({tag, ".right"}, 32'(bus.mag_right), 32'(exp_right));
        chk({tag, ".ns"},    32'(bus.no_signal), 32'(exp_ns));
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) frame[i] = 32'h0;
    endtask

    // drives bins at negedge; report must appear only after the 2nd edge following bin N-1
    task automatic run_frame(input bit hold, input string tag);
        model();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i == 1) chk({tag, ".busy_scan"}, 32'(bus.busy), 32'd1);
            if (i > 0) chk({tag, ".pv_scan"}, 32'(bus.peak_valid), 32'd0);
            bus.in_valid = 1'b1;
            bus.data_in  = frame[i];
        end
        @(negedge clk);
        bus.in_valid = hold;
        bus.data_in  = $urandom;
        chk({tag, ".pv_c1"}, 32'(bus.peak_valid), 32'd0);
        chk({tag, ".busy_flush"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk({tag, ".pv_c2"}, 32'(bus.peak_valid), 32'd0);
        @(negedge clk);
        chk({tag, ".pv_c3"}, 32'(bus.peak_valid), 32'd1);
        chk({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
        check_outs(tag);
        @(negedge clk);
        chk({tag, ".pv_c4"}, 32'(bus.peak_valid), 32'd0);
        check_outs({tag, ".hold"});
    endtask

    initial begin
        int re, im, pulses;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_in  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst.pv",    32'(bus.peak_valid), 32'd0);
        chk("rst.bin",   32'(bus.peak_bin),   32'd0);
        chk("rst.mag",   32'(bus.peak_mag),   32'd0);
        chk("rst.left",  32'(bus.mag_left),   32'd0);
        chk("rst.right", 32'(bus.mag_right),  32'd0);
        chk("rst.ns",    32'(bus.no_signal),  32'd0);
        chk("rst.busy",  32'(bus.busy),       32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        clear_frame(); frame[40] = 32'h1000_0000;
        run_frame(1'b0, "tone");

        clear_frame(); frame[30] = 32'h0800_0800; frame[90] = 32'h0800_0800; frame[31] = 32'h0100_0000;
        run_frame(1'b0, "tie");

        clear_frame(); frame[1] = 32'h7FFF_0000; frame[300] = 32'h7FFF_0000; frame[100] = 32'hFF00_0080;
        run_frame(1'b0, "range");

        clear_frame(); frame[50] = 32'h8000_8000;
        run_frame(1'b0, "neg");

        clear_frame();
        run_frame(1'b0, "empty");

        // peaks at both range edges, with out-of-range neighbours carrying data
        clear_frame(); frame[MAX_BIN] = 32'h0000_0400; frame[MAX_BIN + 1] = 32'h0123_0000;
        frame[MIN_BIN] = 32'h0000_0100; frame[MIN_BIN - 1] = 32'h0777_0000;
        run_frame(1'b0, "edge");

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) frame[i] = $urandom;
            run_frame(1'b0, "rand");
        end

        for (int i = 0; i < N; i++) begin
            re = int'($urandom_range(0, 80)) - 40;
            im = int'($urandom_range(0, 80)) - 40;
            frame[i] = {re[15:0], im[15:0]};
        end
        run_frame(1'b0, "small");

        clear_frame(); frame[150] = 32'h0000_2000;
        for (int i = 0; i <= 200; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.data_in  = frame[i];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.peak_valid) pulses++;
        end
        chk("abort.pulses", 32'(pulses), 32'd0);
        chk("abort.busy", 32'(bus.busy), 32'd0);
        check_outs("abort.held");

        clear_frame(); frame[77] = 32'h0000_0900; frame[78] = 32'h0000_0300;
        run_frame(1'b1, "hold");
        pulses = 0;
        repeat (1000 - N - 4) begin
            @(negedge clk);
            bus.data_in = $urandom;
            if (bus.peak_valid) pulses++;
        end
        chk("hold.pulses", 32'(pulses), 32'd0);
        chk("hold.busy", 32'(bus.busy), 32'd0);
        check_outs("hold.held");
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);

        clear_frame(); frame[40] = 32'h1000_0000;
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.data_in  = frame[i];
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst.pv",    32'(bus.peak_valid), 32'd0);
        chk("midrst.bin",   32'(bus.peak_bin),   32'd0);
        chk("midrst.mag",   32'(bus.peak_mag),   32'd0);
        chk("midrst.left",  32'(bus.mag_left),   32'd0);
        chk("midrst.right", 32'(bus.mag_right),  32'd0);
        chk("midrst.ns",    32'(bus.no_signal),  32'd0);
        chk("midrst.busy",  32'(bus.busy),       32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_frame(1'b0, "postrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/peak_finder.md
PEAK_FINDER -- requirements
Module: peak_finder

Interface
REQ-001 Parameter N, 512, FFT length in bins; bin index width is 9 bits.
REQ-002 Parameter MIN_BIN, 2, lowest bin searched; legal range 1 <= MIN_BIN < MAX_BIN.
REQ-003 Parameter MAX_BIN, 255, highest bin searched; legal range MAX_BIN <= N-2.
REQ-004 Parameter THRESH, 64, magnitude below which a frame is flagged as having no signal.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; reset==0 clears all state immediately.
REQ-007 in_valid  input  1  connected to the FFT done flag; while high, one output bin is presented per cycle, bin 0 first.
REQ-008 data_in  input  32  FFT output word: real part in [31:16], imaginary part in [15:0], both signed two's complement.
REQ-009 peak_valid  output  1  one-cycle pulse marking new report outputs.
REQ-010 peak_bin  output  9  index of the largest-magnitude bin in [MIN_BIN, MAX_BIN].
REQ-011 peak_mag  output  17  magnitude of peak_bin.
REQ-012 mag_left / mag_right  output  17 each  magnitudes of bins peak_bin-1 and peak_bin+1, used for interpolation.
REQ-013 no_signal  output  1  high when the reported peak_mag < THRESH.
REQ-014 busy  output  1  high while the block is in SCAN or FLUSH.

Function
REQ-015 Magnitude is computed as max(|re|,|im|) + (min(|re|,|im|) >> 1), unsigned, 17 bits; |-32768| = 32768 exactly, with no saturation.
REQ-016 FSM states are IDLE, SCAN, FLUSH, and WAIT_LOW; reset enters IDLE.
REQ-017 IDLE -> SCAN on the first edge with in_valid=1; that edge samples bin 0, and the internal bin counter counts samples thereafter.
REQ-018 SCAN accepts one bin per edge while in_valid=1; after the edge sampling bin N-1, the FSM moves to FLUSH.
REQ-019 If in_valid=0 at any edge in SCAN, the frame is aborted: go to IDLE, no peak_valid, and report outputs hold their previous values.
REQ-020 Datapath is two stages: stage 1 registers |re|, |im|, and bin index; stage 2 computes the magnitude and compares it against the running best.
REQ-021 The running best is loaded unconditionally from bin MIN_BIN; thereafter it is replaced only if a bin's magnitude is strictly greater, so ties keep the lowest bin.
REQ-022 Bins outside [MIN_BIN, MAX_BIN] never affect peak_bin or peak_mag.
REQ-023 Whenever the best is loaded or replaced, the stored left-neighbour magnitude is the magnitude of the bin immediately before it.
REQ-024 After the best is loaded or replaced, the magnitude of the immediately following bin is captured as the right-neighbour magnitude; this still applies when the peak is at MAX_BIN.
REQ-025 peak_valid is high for exactly one cycle, asserted in the 3rd cycle after the edge that samples bin N-1.
REQ-026 peak_bin, peak_mag, mag_left, mag_right, and no_signal all update on the edge that asserts peak_valid, and hold until the next report.
REQ-027 After the report, the FSM goes to WAIT_LOW if in_valid=1, otherwise to IDLE; WAIT_LOW ignores data and returns to IDLE on the first edge with in_valid=0.
REQ-028 A held-high in_valid therefore yields exactly one report; a new frame requires in_valid to go low for at least one cycle.
REQ-029 in_valid is ignored during FLUSH; the report still completes.

Reset
REQ-030 Asserting reset (reset=0), asynchronously and at any time including mid-scan, forces IDLE and clears the pipeline and bin counter.
REQ-031 Reset clears all outputs to 0: peak_valid, peak_bin, peak_mag, mag_left, mag_right, no_signal, and busy.
REQ-032 A frame interrupted by reset is never reported; the first full frame after reset release reports normally.

Verification
REQ-033 Tone: all bins 0 except bin 40 = re 0x1000, im 0 -> single pulse 3 cycles after bin 511; peak_bin 40, peak_mag 4096, mag_left 0, mag_right 0, no_signal 0.
REQ-034 Tie and neighbours: bins 30 and 90 = re 0x0800, im 0x0800 (mag 3072), bin 31 = re 0x0100 -> peak_bin 30, peak_mag 3072, mag_right 256, mag_left 0.
REQ-035 Range and sign: bins 1 and 300 = re 0x7FFF, bin 100 = re 0xFF00 (-256), im 0x0080 -> peak_bin 100, peak_mag 320; bin 50 = re 0x8000, im 0x8000 in a separate frame -> peak_mag 49152.
REQ-036 Empty frame: all bins 0 -> peak_bin 2, peak_mag 0, no_signal 1, peak_valid pulses once.
REQ-037 Abort and hold: in_valid drops after bin 200 -> no pulse, previous outputs unchanged; in_valid held high for 1000 cycles -> exactly one pulse.
REQ-038 Reset mid-scan: reset=0 at bin 300 -> all outputs 0 immediately; the next full tone frame (bin 40) reports peak_bin 40.
